lif_block_n: RTL



---
 rtl/lif_pkg.sv | 29 ++
 rtl/lif_accum.sv | 57 +++++
 rtl/lif_block_n.sv | 135 +++++++++++++
 3 files changed

// File: rtl/lif_pkg.sv
// Shared types and helpers for the leaky integrate-and-fire block: FSM encoding,
// membrane width derivation, saturating add and clip.
package lif_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAK,
    ST_ACC,
    ST_FIRE,
    ST_HOLD
  } state_t;

  // Membrane headroom: room for NUM_IN full-scale channels plus two extra bits.
  function automatic int mem_width(input int data_w, input int num_in);
    return data_w + $clog2(num_in) + 2;
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] max_val);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
  endfunction

  function automatic logic [31:0] clip(input logic [31:0] v, input logic [31:0] max_val);
    return (v > max_val) ? max_val : v;
  endfunction

endpackage

// File: rtl/lif_accum.sv
// Membrane potential register: shift leak, saturating channel add, clear on spike,
// and the threshold comparison.
module lif_accum
  import lif_pkg::*;
#(
  parameter int NUM_IN     = 4,
  parameter int DATA_W     = 4,
  parameter int LEAK_SHIFT = 2,
  parameter int THRESHOLD  = 20,
  parameter int MEM_W      = mem_width(DATA_W, NUM_IN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              leak_en,
  input  logic              add_en,
  input  logic [DATA_W-1:0] add_val,
  output logic [MEM_W-1:0]  mem,
  output logic              fire
);

  localparam logic [MEM_W-1:0] MEM_MAX = '1;
  localparam logic [MEM_W-1:0] THRESH  = MEM_W'(THRESHOLD);

  logic [MEM_W-1:0] mem_reg, mem_next, leak_amt;

  generate
    if (LEAK_SHIFT == 0) begin : g_no_leak
      assign leak_amt = '0;
    end else begin : g_leak
      assign leak_amt = mem_reg >> LEAK_SHIFT;
    end
  endgenerate

  always_comb begin
    mem_next = mem_reg;
    if (clear) begin
      mem_next = '0;
    end else if (leak_en) begin
      mem_next = mem_reg - leak_amt;
    end else if (add_en) begin
      mem_next = MEM_W'(sat_add(32'(mem_reg), 32'(add_val), 32'(MEM_MAX)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_reg <= '0;
    end else begin
      mem_reg <= mem_next;
    end
  end

  assign mem  = mem_reg;
  assign fire = (mem_reg >= THRESH);

endmodule

// File: rtl/lif_block_n.sv
// Multi-channel LIF node: valid/ready capture, sequential integration, spike + level out.
// Optional refractory period enabled by defining LIF_BLOCK_REFRACTORY_EN.
module lif_block_n
  import lif_pkg::*;
#(
  parameter int NUM_IN         = 4,
  parameter int DATA_W         = 4,
  parameter int LEAK_SHIFT     = 2,
  parameter int THRESHOLD      = 20,
  parameter int REFRACT_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DATA_W-1:0]        out_level,
  output logic                     out_spike,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     proc,
  output logic                     rdy
);

  localparam int MEM_W = mem_width(DATA_W, NUM_IN);
  localparam int IDX_W = $clog2(NUM_IN);
  localparam logic [DATA_W-1:0] LEVEL_MAX = '1;

  state_t state_reg, state_next;
  logic [IDX_W-1:0]         ch_idx_reg;
  logic [NUM_IN*DATA_W-1:0] data_reg;
  logic [DATA_W-1:0]        ch [NUM_IN];
  logic [DATA_W-1:0]        out_level_reg;
  logic                     out_spike_reg;
  logic [MEM_W-1:0]         mem;
  logic                     fire;
  logic                     accept;
  logic                     skip;
  logic                     refr_active;

  generate
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_unpack
      assign ch[gi] = data_reg[gi*DATA_W +: DATA_W];
    end
  endgenerate

  assign accept = (state_reg == ST_IDLE) && in_valid;

  lif_accum #(
    .NUM_IN    (NUM_IN),
    .DATA_W    (DATA_W),
    .LEAK_SHIFT(LEAK_SHIFT),
    .THRESHOLD (THRESHOLD),
    .MEM_W     (MEM_W)
  ) u_accum (
    .clk    (clk),
    .rst    (rst),
    .clear  ((state_reg == ST_FIRE) && fire && !skip),
    .leak_en(state_reg == ST_LEAK),
    .add_en (state_reg == ST_ACC),
    .add_val(ch[ch_idx_reg]),
    .mem    (mem),
    .fire   (fire)
  );

`ifdef LIF_BLOCK_REFRACTORY_EN
  localparam int RW = $clog2(REFRACT_CYCLES + 2);
  logic [RW-1:0] refr_cnt_reg;
  logic          skip_reg;

  // skip_reg marks a vector accepted during the refractory window; it bypasses integration.
  always_ff @(posedge clk) begin
    if (rst) begin
      refr_cnt_reg <= '0;
      skip_reg     <= 1'b0;
    end else begin
      if (accept) begin
        skip_reg <= (refr_cnt_reg != '0);
        if (refr_cnt_reg != '0) begin
          refr_cnt_reg <= refr_cnt_reg - 1'b1;
        end
      end
      if ((state_reg == ST_FIRE) && fire && !skip_reg) begin
        refr_cnt_reg <= RW'(REFRACT_CYCLES);
      end
    end
  end

  assign refr_active = (refr_cnt_reg != '0);
  assign skip        = skip_reg;
`else
  assign refr_active = 1'b0;
  assign skip        = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (in_valid) state_next = refr_active ? ST_FIRE : ST_LEAK;
      ST_LEAK: state_next = ST_ACC;
      ST_ACC:  if (ch_idx_reg == IDX_W'(NUM_IN - 1)) state_next = ST_FIRE;
      ST_FIRE: state_next = ST_HOLD;
      ST_HOLD: if (out_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      ch_idx_reg    <= '0;
      data_reg      <= '0;
      out_level_reg <= '0;
      out_spike_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) data_reg <= in_data;
      if (state_reg == ST_LEAK) ch_idx_reg <= '0;
      if (state_reg == ST_ACC) ch_idx_reg <= ch_idx_reg + 1'b1;
      // Level is the pre-fire potential, taken before the spike clears mem.
      if (state_reg == ST_FIRE) begin
        out_level_reg <= skip ? '0 : DATA_W'(clip(32'(mem), 32'(LEVEL_MAX)));
        out_spike_reg <= fire && !skip;
      end
    end
  end

  assign in_ready  = (state_reg == ST_IDLE);
  assign rdy       = in_ready;
  assign proc      = (state_reg == ST_LEAK) || (state_reg == ST_ACC) || (state_reg == ST_FIRE);
  assign out_valid = (state_reg == ST_HOLD);
  assign out_level = out_level_reg;
  assign out_spike = out_spike_reg;

endmodule
